// File: rtl/axis_rand_range_if.sv
// AXI-Stream style word channel shared by the range scaler's input and output sides.
// The master drives data and valid, and the slave drives ready.
interface axis_rand_range_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_rand_range.sv
// Scales a uniform 32-bit word into [0, range) as floor(x*range/2^32) with a serial shift-add multiplier.
// Accept -> result after 32/STEP_BITS cycles; one word in flight; the result holds until taken.
module axis_rand_range #(
  parameter int STEP_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  axis_rand_range_if.slave    input_axis,
  axis_rand_range_if.master   output_axis,
  input  logic [31:0]         range_val,
  output logic                busy,
  output logic [31:0]         out_count
);

  localparam int         C      = 32 / STEP_BITS;
  localparam logic [5:0] C_LOAD = 6'(C);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_x;
  logic [31:0] r_r;
  logic        r_full;
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic [4:0]  r_pos;
  logic [31:0] r_tdata;
  logic        r_tvalid;
  logic [31:0] r_count;

  logic                 w_in_rdy;
  logic                 w_accept;
  logic                 w_out_hs;
  logic [STEP_BITS-1:0] w_digit;
  logic [63:0]          w_term;
  logic [63:0]          w_acc_next;

  assign w_in_rdy = (r_state == ST_IDLE) && !rst;
  assign w_accept = w_in_rdy && input_axis.tvalid;
  assign w_out_hs = (r_state == ST_OUT) && r_tvalid && output_axis.tready;

  // Partial product of the next multiplier digit, aligned to its bit position.
  assign w_digit    = r_r[STEP_BITS-1:0];
  assign w_term     = ({32'd0, r_x} * {{(64-STEP_BITS){1'b0}}, w_digit}) << r_pos;
  assign w_acc_next = r_acc + w_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_x      <= 32'd0;
      r_r      <= 32'd0;
      r_full   <= 1'b0;
      r_acc    <= 64'd0;
      r_cnt    <= 6'd0;
      r_pos    <= 5'd0;
      r_tdata  <= 32'd0;
      r_tvalid <= 1'b0;
      r_count  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x     <= input_axis.tdata;
            r_r     <= range_val;
            r_full  <= (range_val == 32'd0);
            r_acc   <= 64'd0;
            r_cnt   <= C_LOAD;
            r_pos   <= 5'd0;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc <= w_acc_next;
          r_r   <= r_r >> STEP_BITS;
          r_cnt <= r_cnt - 6'd1;
          r_pos <= r_pos + 5'(STEP_BITS);
          if (r_cnt == 6'd1) begin
            // A zero range stands for 2^32, so the word passes through unscaled.
            r_tdata  <= r_full ? r_x : w_acc_next[63:32];
            r_tvalid <= 1'b1;
            r_state  <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (w_out_hs) begin
            r_tvalid <= 1'b0;
            r_count  <= r_count + 32'd1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tvalid <= 1'b0;
        end
      endcase
    end
  end

  assign input_axis.tready  = w_in_rdy;
  assign output_axis.tdata  = r_tdata;
  assign output_axis.tvalid = r_tvalid;
  assign busy               = (r_state == ST_MUL) || (r_state == ST_OUT);
  assign out_count          = r_count;

endmodule

// File: tb/tb_axis_rand_range.sv
// Bench for axis_rand_range: directed cases on a STEP_BITS=1 instance and a randomized
// back-to-back stream on a STEP_BITS=4 instance, both checked against floor(x*r/2^32).
module tb_axis_rand_range;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] range1, range4;
  logic        busy1, busy4;
  logic [31:0] cnt1, cnt4;

  int total = 0;
  int bad   = 0;
  int exp_cnt1 = 0;

  always #5 clk = ~clk;

  axis_rand_range_if in1();
  axis_rand_range_if out1();
  axis_rand_range_if in4();
  axis_rand_range_if out4();

  axis_rand_range #(.STEP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .input_axis(in1), .output_axis(out1),
    .range_val(range1), .busy(busy1), .out_count(cnt1)
  );

  axis_rand_range #(.STEP_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .input_axis(in4), .output_axis(out4),
    .range_val(range4), .busy(busy4), .out_count(cnt4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: range 0 means 2^32, so the word itself; otherwise the high half of x*r.
  function automatic logic [31:0] scale(input logic [31:0] x, input logic [31:0] r);
    logic [63:0] prod;
    if (r == 32'd0) return x;
    prod = 64'(x) * 64'(r);
    return prod[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] x, input logic [31:0] rng, input logic [31:0] post_rng,
                       input int hold, input logic [31:0] exp);
    int n;
    logic stable;
    logic [31:0] seen;
    n = 0;
    while (!in1.tready && n < 50) begin tick(); n++; end
    check("in_ready", in1.tready, 1);
    in1.tdata = x; in1.tvalid = 1'b1; range1 = rng;
    tick();
    in1.tvalid = 1'b0; in1.tdata = $urandom; range1 = post_rng;
    check("busy_mul", busy1, 1);
    n = 0;
    while (!out1.tvalid && n < 100) begin tick(); n++; end
    check("latency1", n, 32);
    check("data1", out1.tdata, exp);
    seen = out1.tdata; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!out1.tvalid || out1.tdata !== seen || in1.tready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", stable, 1);
    out1.tready = 1'b1;
    tick();
    out1.tready = 1'b0;
    exp_cnt1++;
    check("vld_drop", out1.tvalid, 0);
    check("count1", cnt1, exp_cnt1);
    check("idle_ready", in1.tready, 1);
  endtask

  initial begin
    logic [31:0] xr, rr;
    logic seen_vld;
    int cyc, last_acc, got_n;
    logic [31:0] q[$];

    rst = 1'b1;
    in1.tdata = 0; in1.tvalid = 0; out1.tready = 0; range1 = 0;
    in4.tdata = 0; in4.tvalid = 0; out4.tready = 0; range4 = 0;
    tick(); tick();
    check("rst_in_rdy1", in1.tready, 0);
    check("rst_vld1", out1.tvalid, 0);
    check("rst_dat1", out1.tdata, 0);
    check("rst_busy1", busy1, 0);
    check("rst_cnt1", cnt1, 0);
    check("rst_in_rdy4", in4.tready, 0);
    rst = 1'b0;
    #1;
    check("rel_rdy1", in1.tready, 1);
    check("rel_rdy4", in4.tready, 1);

    // Ready with no valid result must not count a handshake.
    out1.tready = 1'b1;
    repeat (5) tick();
    out1.tready = 1'b0;
    check("idle_tready_cnt", cnt1, 0);

    send1(32'hFFFF_FFFF, 32'd10,  32'd10, 0, 32'd9);
    send1(32'h8000_0000, 32'd6,   32'd6,  0, 32'd3);
    send1(32'h0000_0000, 32'd100, 32'd7,  0, 32'd0);
    send1(32'h1234_5678, 32'd0,   32'd5,  0, 32'h1234_5678);
    xr = $urandom; rr = $urandom;
    send1(xr, rr, $urandom, 50, scale(xr, rr));
    send1(32'hFFFF_FFFF, 32'd10, 32'd1000, 0, 32'd9);
    for (int i = 0; i < 5; i++) begin
      xr = $urandom;
      rr = (i == 2) ? 32'hFFFF_FFFF : $urandom_range(1, 1000);
      send1(xr, rr, $urandom, 0, scale(xr, rr));
    end

    // Reset while multiplying: the in-flight word must vanish.
    in1.tdata = 32'hFFFF_FFFF; in1.tvalid = 1'b1; range1 = 32'd10;
    tick();
    in1.tvalid = 1'b0;
    out1.tready = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("mrst_in_rdy", in1.tready, 0);
    check("mrst_busy", busy1, 0);
    check("mrst_vld", out1.tvalid, 0);
    check("mrst_cnt", cnt1, 0);
    rst = 1'b0;
    #1;
    check("mrst_rel_rdy", in1.tready, 1);
    seen_vld = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out1.tvalid) seen_vld = 1'b1;
    end
    check("mrst_no_out", seen_vld, 0);
    check("mrst_cnt_after", cnt1, 0);
    out1.tready = 1'b0;

    // STEP_BITS=4: continuous random stream, range_val churning every cycle.
    cyc = 0; last_acc = -1; got_n = 0;
    in4.tvalid = 1'b1; in4.tdata = $urandom; range4 = $urandom;
    for (int i = 0; i < 1500 && got_n < 30; i++) begin
      logic acc, oh, pv;
      logic [31:0] odat;
      acc  = in4.tvalid && in4.tready;
      oh   = out4.tvalid && out4.tready;
      pv   = out4.tvalid;
      odat = out4.tdata;
      tick();
      cyc++;
      if (acc) begin
        if (last_acc >= 0) check("spacing4", (cyc - last_acc) >= 10, 1);
        last_acc = cyc;
        q.push_back(scale(in4.tdata, range4));
        in4.tdata = $urandom;
      end
      if (oh) begin
        got_n++;
        if (q.size() == 0) check("q_underflow", 1, 0);
        else check("data4", odat, q.pop_front());
      end
      if (!pv && out4.tvalid) check("latency4", cyc - last_acc, 8);
      case ($urandom_range(0, 3))
        0: range4 = 32'd0;
        1: range4 = $urandom_range(1, 100);
        default: range4 = $urandom;
      endcase
      out4.tready = 1'($urandom_range(0, 1));
    end
    check("drained4", got_n, 30);
    check("count4", cnt4, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
